// File: rtl/hazard_ctrl.sv
// Stall/bubble controller: Tuse/Tnew data-hazard detection plus mult/div busy tracking.
// Optional stall statistics counters are enabled by defining HAZARD_STAT_EN.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic       d_use_rs,
  input  logic       d_use_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic       d_is_md,
  input  logic [4:0] e_wa,
  input  logic [1:0] e_tnew,
  input  logic [4:0] m_wa,
  input  logic [1:0] m_tnew,
  input  logic       e_md_start,
  input  logic       e_md_is_div,
  output logic       pc_en,
  output logic       fd_pause,
  output logic       de_clr,
  output logic       md_busy
`ifdef HAZARD_STAT_EN
  ,
  output logic [31:0] stall_data_cnt,
  output logic [31:0] stall_md_cnt
`endif
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_rs, stall_rt, stall_data, stall_md, stall;

  // A start while already busy is ignored; the D-stage md stall prevents it.
  always_comb begin
    cnt_d = cnt_q;
    if (e_md_start && (cnt_q == '0)) begin
      cnt_d = e_md_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign md_busy = (cnt_q != '0);

  // Register $0 is never a real producer, so it is excluded from both matches.
  always_comb begin
    stall_rs = d_use_rs && (d_rs != 5'd0) &&
               (((d_rs == e_wa) && (d_tuse_rs < e_tnew)) ||
                ((d_rs == m_wa) && (d_tuse_rs < m_tnew)));
    stall_rt = d_use_rt && (d_rt != 5'd0) &&
               (((d_rt == e_wa) && (d_tuse_rt < e_tnew)) ||
                ((d_rt == m_wa) && (d_tuse_rt < m_tnew)));
    stall_data = stall_rs || stall_rt;
    stall_md   = d_is_md && (md_busy || e_md_start);
    stall      = stall_data || stall_md;
  end

  assign pc_en    = ~stall;
  assign fd_pause = stall;
  assign de_clr   = stall;

`ifdef HAZARD_STAT_EN
  logic [31:0] data_cnt_q, data_cnt_d;
  logic [31:0] md_cnt_q, md_cnt_d;

  // md stalls are only counted when no data stall is present, so no cycle counts twice.
  always_comb begin
    data_cnt_d = data_cnt_q;
    md_cnt_d   = md_cnt_q;
    if (stall_data) begin
      data_cnt_d = data_cnt_q + 32'd1;
    end else if (stall_md) begin
      md_cnt_d = md_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_cnt_q <= '0;
      md_cnt_q   <= '0;
    end else begin
      data_cnt_q <= data_cnt_d;
      md_cnt_q   <= md_cnt_d;
    end
  end

  assign stall_data_cnt = data_cnt_q;
  assign stall_md_cnt   = md_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl; define HAZARD_STAT_EN to also check the stall counters.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, e_wa, m_wa;
  logic       d_use_rs, d_use_rt, d_is_md, e_md_start, e_md_is_div;
  logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic       pc_en, fd_pause, de_clr, md_busy;
`ifdef HAZARD_STAT_EN
  logic [31:0] stall_data_cnt, stall_md_cnt;
`endif

  int unsigned passes = 0;
  int unsigned total  = 0;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_is_md(d_is_md),
    .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
    .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .pc_en(pc_en), .fd_pause(fd_pause), .de_clr(de_clr), .md_busy(md_busy)
`ifdef HAZARD_STAT_EN
    , .stall_data_cnt(stall_data_cnt), .stall_md_cnt(stall_md_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Checks all three stall outputs together against one expected stall bit.
  task automatic chk_stall(input string tag, input logic exp_stall);
    chk({tag, ".pc_en"},    {31'd0, pc_en},    {31'd0, ~exp_stall});
    chk({tag, ".fd_pause"}, {31'd0, fd_pause}, {31'd0, exp_stall});
    chk({tag, ".de_clr"},   {31'd0, de_clr},   {31'd0, exp_stall});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    d_rs = '0; d_rt = '0; d_use_rs = 1'b0; d_use_rt = 1'b0;
    d_tuse_rs = '0; d_tuse_rt = '0; d_is_md = 1'b0;
    e_wa = '0; e_tnew = '0; m_wa = '0; m_tnew = '0;
    e_md_start = 1'b0; e_md_is_div = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("reset.md_busy", {31'd0, md_busy}, 32'd0);
    chk_stall("reset", 1'b0);

    // Load-use on rs from E
    e_wa = 5'd8; e_tnew = 2'd2; d_rs = 5'd8; d_use_rs = 1'b1; d_tuse_rs = 2'd1;
    #1 chk_stall("loaduse_e", 1'b1);
    step();
    e_wa = 5'd0; m_wa = 5'd8; m_tnew = 2'd1;
    #1 chk_stall("m_tnew1_tuse1", 1'b0);
    d_tuse_rs = 2'd0;
    #1 chk_stall("m_tnew1_tuse0", 1'b1);
    m_tnew = 2'd0;
    #1 chk_stall("m_tnew0", 1'b0);
    d_use_rs = 1'b0; m_tnew = 2'd2;
    #1 chk_stall("rs_not_used", 1'b0);

    // $0 immunity in both stages
    idle_inputs();
    e_wa = 5'd0; e_tnew = 2'd2; m_wa = 5'd0; m_tnew = 2'd2;
    d_rs = 5'd0; d_use_rs = 1'b1; d_tuse_rs = 2'd0;
    d_rt = 5'd0; d_use_rt = 1'b1; d_tuse_rt = 2'd0;
    #1 chk_stall("zero_reg", 1'b0);

    // rt against M
    idle_inputs();
    m_wa = 5'd9; m_tnew = 2'd1; d_rt = 5'd9; d_use_rt = 1'b1; d_tuse_rt = 2'd1;
    #1 chk_stall("rt_tuse_ok", 1'b0);
    d_tuse_rt = 2'd0;
    #1 chk_stall("rt_tuse_short", 1'b1);
    d_rt = 5'd10;
    #1 chk_stall("rt_other_reg", 1'b0);
    // rt against E while M is unrelated
    e_wa = 5'd10; e_tnew = 2'd1;
    #1 chk_stall("rt_e_stage", 1'b1);

    // Mult: start cycle stalls, then exactly 5 busy cycles
    idle_inputs();
    step();
    d_is_md = 1'b1; e_md_start = 1'b1; e_md_is_div = 1'b0;
    #1;
    chk("mult_start.md_busy", {31'd0, md_busy}, 32'd0);
    chk_stall("mult_start", 1'b1);
    step();
    e_md_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      // A stray div start mid-countdown must not reload the counter
      e_md_start = (i == 2);
      e_md_is_div = (i == 2);
      #1;
      chk($sformatf("mult_busy%0d", i), {31'd0, md_busy}, 32'd1);
      chk_stall($sformatf("mult_stall%0d", i), 1'b1);
      step();
      e_md_start = 1'b0;
      e_md_is_div = 1'b0;
    end
    chk("mult_done.md_busy", {31'd0, md_busy}, 32'd0);
    chk_stall("mult_done", 1'b0);
    d_is_md = 1'b0;
    e_md_start = 1'b1;
    #1 chk_stall("start_no_md_in_d", 1'b0);
    step();
    e_md_start = 1'b0;
    chk("start_no_md_in_d.busy", {31'd0, md_busy}, 32'd1);
    d_is_md = 1'b1;
    #1 chk_stall("md_in_d_busy", 1'b1);

    // Div interrupted by reset
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    d_is_md = 1'b1; e_md_start = 1'b1; e_md_is_div = 1'b1;
    step();
    e_md_start = 1'b0; e_md_is_div = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("div_busy%0d", i), {31'd0, md_busy}, 32'd1);
      if (i < 2) step();
    end
    reset = 1'b1;
    #1 chk_stall("div_pre_reset", 1'b1);
    step();
    reset = 1'b0;
    #1;
    chk("div_reset.md_busy", {31'd0, md_busy}, 32'd0);
    chk_stall("div_reset", 1'b0);

`ifdef HAZARD_STAT_EN
    idle_inputs();
    chk("stat_reset.data", stall_data_cnt, 32'd0);
    chk("stat_reset.md", stall_md_cnt, 32'd0);
    e_wa = 5'd3; e_tnew = 2'd2; d_rs = 5'd3; d_use_rs = 1'b1; d_tuse_rs = 2'd0;
    d_is_md = 1'b1;
    for (int i = 0; i < 3; i++) step();
    idle_inputs();
    e_md_start = 1'b1;
    step();
    e_md_start = 1'b0;
    d_is_md = 1'b1;
    for (int i = 0; i < 5; i++) step();
    d_is_md = 1'b0;
    step();
    chk("stat.data", stall_data_cnt, 32'd3);
    chk("stat.md", stall_md_cnt, 32'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("stat_clr.data", stall_data_cnt, 32'd0);
    chk("stat_clr.md", stall_md_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
